// File: rtl/dmem_responder.sv
// Big-endian byte-addressable data memory slave with sub-word access, misalignment tracking
// and an optional post-reset zeroing sweep (enabled by defining DMEM_ZERO_INIT_EN).
module dmem_responder #(
    parameter int Depth    = 1024,
    parameter int AddrBits = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] MemAddr,
    input  logic [0:31] MemWData,
    input  logic        MemWE,
    input  logic [0:1]  MemSize,
    input  logic        MemExt,
    output logic [0:31] DMEM_Dout,
    output logic        Ready,
    output logic        MisalignErr,
    output logic [0:7]  ErrCount
);

    typedef enum logic {INIT, READY} state_t;

    state_t               state, state_nxt;
    logic [31:0]          mem [Depth];
    logic [31:0]          addr, wdata, rword, rdata, wmask, wal;
    logic [AddrBits-1:0]  widx;
    logic [1:0]           off, size;
    logic [7:0]           err_cnt, bsel;
    logic [15:0]          hsel;
    logic                 mis, ready_st, wr_en, sweep_done, addr_unused;

    // Ascending port ranges carry MSB-first values; internal vectors are value-equivalent.
    assign addr        = MemAddr;
    assign wdata       = MemWData;
    assign size        = MemSize;
    assign widx        = addr[AddrBits+1:2];
    assign off         = addr[1:0];
    assign addr_unused = ^addr[31:AddrBits+2];

    assign ready_st = (state == READY);
    assign mis      = ((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00));
    assign wr_en    = ready_st && MemWE && !mis;
    assign rword    = mem[widx];

`ifdef DMEM_ZERO_INIT_EN
    logic [AddrBits-1:0] sweep_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sweep_cnt <= '0;
        else if (state == INIT)
            sweep_cnt <= sweep_cnt + 1'b1;
    end

    assign sweep_done = (sweep_cnt == AddrBits'(Depth - 1));
`else
    assign sweep_done = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep_done) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            MisalignErr <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            MisalignErr <= ready_st && mis;
            if (ready_st && mis && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign Ready    = ready_st;
    assign ErrCount = err_cnt;

    // Byte lane 0 is the most significant byte; store data is replicated and masked into place.
    always_comb begin
        wmask = '1;
        wal   = wdata;
        case (size)
            2'b00: begin
                wmask = 32'hFF00_0000 >> {off, 3'b000};
                wal   = {4{wdata[7:0]}};
            end
            2'b01: begin
                wmask = off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                wal   = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
        if (state == INIT)
            mem[sweep_cnt] <= '0;
`endif
        if (wr_en)
            mem[widx] <= (rword & ~wmask) | (wal & wmask);
    end

    always_comb begin
        bsel  = 8'(rword >> {~off, 3'b000});
        hsel  = off[1] ? rword[15:0] : rword[31:16];
        case (size)
            2'b00:   rdata = {{24{MemExt & bsel[7]}}, bsel};
            2'b01:   rdata = {{16{MemExt & hsel[15]}}, hsel};
            default: rdata = rword;
        endcase
        if (!reset || !ready_st || mis)
            rdata = '0;
    end

    assign DMEM_Dout = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset/sweep sequences and
// randomized accesses checked against a byte-array model of the memory.
module tb_dmem_responder;

    localparam int Depth    = 1024;
    localparam int AddrBits = 10;
    localparam int NBYTES   = Depth * 4;
`ifdef DMEM_ZERO_INIT_EN
    localparam int INIT_CYC = Depth;
`else
    localparam int INIT_CYC = 1;
`endif

    logic        clk;
    logic        reset;
    logic [0:31] MemAddr;
    logic [0:31] MemWData;
    logic        MemWE;
    logic [0:1]  MemSize;
    logic        MemExt;
    logic [0:31] DMEM_Dout;
    logic        Ready;
    logic        MisalignErr;
    logic [0:7]  ErrCount;

    dmem_responder #(.Depth(Depth), .AddrBits(AddrBits)) dut (
        .clk(clk), .reset(reset), .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE),
        .MemSize(MemSize), .MemExt(MemExt), .DMEM_Dout(DMEM_Dout), .Ready(Ready),
        .MisalignErr(MisalignErr), .ErrCount(ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: flat big-endian byte array plus a per-word "contents known" flag.
    logic [7:0] mb    [NBYTES];
    bit         known [Depth];
    int         err_model = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        bit          we;
        logic [1:0]  sz;
        bit          ext;
        bit          cd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            pass_cnt++;
    endtask

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input logic [1:0] sz, input bit ext);
        int unsigned ba;
        logic [15:0] h;
        ba = a % NBYTES;
        if (misal(a, sz)) return 32'h0;
        case (sz)
            2'd0: return (ext && mb[ba][7]) ? {24'hFFFFFF, mb[ba]} : {24'h0, mb[ba]};
            2'd1: begin
                h = {mb[ba], mb[ba+1]};
                return (ext && h[15]) ? {16'hFFFF, h} : {16'h0, h};
            end
            default: begin
                ba = ba - (ba % 4);
                return {mb[ba], mb[ba+1], mb[ba+2], mb[ba+3]};
            end
        endcase
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int unsigned ba;
        ba = a % NBYTES;
        case (sz)
            2'd0: mb[ba] = wd[7:0];
            2'd1: begin mb[ba] = wd[15:8]; mb[ba+1] = wd[7:0]; end
            default: begin
                mb[ba] = wd[31:24]; mb[ba+1] = wd[23:16]; mb[ba+2] = wd[15:8]; mb[ba+3] = wd[7:0];
                known[ba/4] = 1'b1;
            end
        endcase
    endfunction

    function automatic void model_clear(input bit zero);
        for (int i = 0; i < NBYTES; i++) if (zero) mb[i] = 8'h00;
        for (int i = 0; i < Depth; i++) if (zero) known[i] = 1'b1;
        err_model = 0;
    endfunction

    // One access: starts just after a rising edge, ends just after the next one.
    task automatic acc(input logic [31:0] a, input logic [31:0] wd, input bit we,
                       input logic [1:0] sz, input bit ext, output logic [31:0] got);
        bit m;
        int unsigned wi;
        MemAddr = a; MemWData = wd; MemWE = we; MemSize = sz; MemExt = ext;
        #2;
        got = DMEM_Dout;
        m   = misal(a, sz);
        wi  = (a % NBYTES) / 4;
        if (m || known[wi]) chk("dout", got, mread(a, sz, ext));
        @(posedge clk); #1;
        if (m) begin
            if (err_model < 255) err_model++;
        end else if (we) begin
            mwrite(a, wd, sz);
        end
        chk("misalign_err", MisalignErr, 32'(m));
        chk("err_count", ErrCount, err_model);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (Ready !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, INIT_CYC);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input bit we,
                                input logic [1:0] sz, input bit ext, input bit cd,
                                input logic [31:0] exp);
        vec_t v;
        v.a = a; v.wd = wd; v.we = we; v.sz = sz; v.ext = ext; v.cd = cd; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [31:0] got;
        logic [31:0] ra;

        tbl[0]  = mk(32'h10, 32'h812345F6, 1, 2, 0, 0, 32'h0);
        tbl[1]  = mk(32'h10, 32'h0, 0, 0, 1, 1, 32'hFFFFFF81);
        tbl[2]  = mk(32'h11, 32'h0, 0, 0, 1, 1, 32'h00000023);
        tbl[3]  = mk(32'h12, 32'h0, 0, 0, 1, 1, 32'h00000045);
        tbl[4]  = mk(32'h13, 32'h0, 0, 0, 1, 1, 32'hFFFFFFF6);
        tbl[5]  = mk(32'h10, 32'h0, 0, 0, 0, 1, 32'h00000081);
        tbl[6]  = mk(32'h11, 32'h0, 0, 0, 0, 1, 32'h00000023);
        tbl[7]  = mk(32'h12, 32'h0, 0, 0, 0, 1, 32'h00000045);
        tbl[8]  = mk(32'h13, 32'h0, 0, 0, 0, 1, 32'h000000F6);
        tbl[9]  = mk(32'h20, 32'h11223344, 1, 2, 0, 0, 32'h0);
        tbl[10] = mk(32'h22, 32'h0000BEEF, 1, 1, 0, 1, 32'h00003344);
        tbl[11] = mk(32'h20, 32'h0, 0, 2, 0, 1, 32'h1122BEEF);
        tbl[12] = mk(32'h22, 32'h0, 0, 1, 1, 1, 32'hFFFFBEEF);
        tbl[13] = mk(32'h21, 32'h0, 0, 0, 1, 1, 32'h00000022);
        tbl[14] = mk(32'h20, 32'h0, 0, 3, 1, 1, 32'h1122BEEF);
        tbl[15] = mk(32'h40, 32'h01020304, 1, 2, 0, 0, 32'h0);
        tbl[16] = mk(32'h41, 32'hDEADBEEF, 1, 2, 0, 1, 32'h0);
        tbl[17] = mk(32'h40, 32'h0, 0, 2, 0, 1, 32'h01020304);
        tbl[18] = mk(NBYTES + 8, 32'hCAFEF00D, 1, 2, 0, 0, 32'h0);
        tbl[19] = mk(32'h08, 32'h0, 0, 2, 0, 1, 32'hCAFEF00D);
        tbl[20] = mk(32'h23, 32'h0, 0, 1, 1, 1, 32'h0);

        for (int i = 0; i < Depth; i++) known[i] = 1'b0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;

        // Reset state
        reset = 1'b0; MemAddr = '0; MemWData = '0; MemWE = 1'b0; MemSize = 2'd2; MemExt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", Ready, 0);
        chk("rst_misalign", MisalignErr, 0);
        chk("rst_errcount", ErrCount, 0);
        chk("rst_dout", DMEM_Dout, 0);

        // Release with a misaligned store pending: INIT must neither write nor count it
        reset = 1'b1; MemAddr = 32'h41; MemWE = 1'b1; MemWData = 32'hFFFFFFFF;
        #1;
        chk("init_dout", DMEM_Dout, 0);
        wait_ready("init_cycles");
        MemAddr = '0; MemWE = 1'b0;
        chk("init_errcount", ErrCount, 0);
`ifdef DMEM_ZERO_INIT_EN
        model_clear(1'b1);
        acc(32'h3FC, 32'h0, 0, 2, 0, got);
        chk("swept_word", got, 32'h0);
`endif

        // Directed table
        for (int i = 0; i < 21; i++) begin
            acc(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].sz, tbl[i].ext, got);
            if (tbl[i].cd) chk($sformatf("tbl%0d", i), got, tbl[i].exp);
        end

        // Random traffic over a small prefilled window, with address aliases
        for (int w = 0; w < 16; w++) acc(w * 4, $urandom, 1, 2, 0, got);
        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(0, 63) + $urandom_range(0, 2) * NBYTES;
            acc(ra, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), got);
        end

        // Saturation under continuous misaligned halfword accesses
        for (int i = 0; i < 300; i++) acc(2 * ($urandom_range(0, 31)) + 1, $urandom, 1'($urandom), 1, 0, got);
        chk("err_saturated", ErrCount, 255);

`ifdef DMEM_ZERO_INIT_EN
        // Reset partway through a sweep restarts it
        reset = 1'b0; #1;
        reset = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("mid_sweep_ready", Ready, 0);
`endif
        reset = 1'b0; #1;
        chk("rst2_dout", DMEM_Dout, 0);
        chk("rst2_errcount", ErrCount, 0);
        chk("rst2_ready", Ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        wait_ready("reinit_cycles");
`ifdef DMEM_ZERO_INIT_EN
        model_clear(1'b1);
`else
        model_clear(1'b0);
`endif
        acc(32'h20, 32'h0, 0, 2, 0, got);
        acc(32'h41, 32'h0, 0, 2, 0, got);
        chk("post_errcount", ErrCount, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor: the slave end of the processor's data-memory port, driven by MemAddr, MemWData, MemWE, MemSize and MemExt, returning DMEM_Dout. It holds a big-endian, byte-addressable word array. It performs sub-word writes with byte lanes and sub-word reads with sign or zero extension. It also runs a post-reset clearing sweep and detects and counts misaligned accesses. It is instantiated beside the processor in the system testbench/top.

## Interface
- Depth, 1024: number of 32-bit words; power of two.
- AddrBits, 10: log2(Depth); word index is MemAddr[30-AddrBits:29].
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemAddr  in  [0:31]  byte address; bits above the word index are ignored, so addresses wrap modulo Depth*4.
- MemWData  in  [0:31]  store data, right-justified for byte/half.
- MemWE  in  1  write enable for this cycle.
- MemSize  in  [0:1]  00 byte, 01 halfword, 10 word, 11 treated as word.
- MemExt  in  1  1 = sign-extend sub-word reads, 0 = zero-extend.
- DMEM_Dout  out  [0:31]  read data, combinational from the array.
- Ready  out  1  registered; high once the memory accepts accesses.
- MisalignErr  out  1  registered one-cycle pulse on a misaligned access.
- ErrCount  out  [0:7]  registered saturating count of misaligned accesses.

## Operation
- Byte order is big-endian: offset 0 maps to bits [0:7] and offset 3 to bits [24:31]. Halfword offset 0 maps to [0:15] and offset 2 to [16:31].
- FSM states: INIT → READY. Reset forces INIT with the sweep counter at 0.
- INIT:
  - Each cycle, word[counter] is written with 0 and the counter increments.
  - After word Depth-1 is written, the FSM moves to READY.
  - MemWE is ignored and DMEM_Dout reads 0.
- READY:
  - Normal accesses. The FSM stays in READY until reset.
- Alignment:
  - A halfword access with MemAddr[31]=1 is misaligned.
  - A word access with MemAddr[30:31]≠00 is misaligned.
  - A byte access is never misaligned.
- Misaligned access in READY:
  - The write is suppressed and DMEM_Dout reads 0.
  - MisalignErr is high for the following cycle.
  - ErrCount increments and saturates at 255.
  - This applies whether or not MemWE is set.
- Writes:
  - Only the addressed byte lanes of the word change, on the rising clk edge while MemWE=1.
  - Byte stores take MemWData[24:31]; halfword stores take MemWData[16:31].
- Reads:
  - Always active; there is no read-enable.
  - A byte read takes the selected lane, placed in [24:31].
  - A halfword read takes the selected half, placed in [16:31].
  - Upper bits are filled with copies of the lane MSB if MemExt=1, otherwise with 0.
  - A word read returns the word unchanged; MemExt is ignored.
- Read-during-write to the same address: DMEM_Dout shows the old contents until the edge, and the new value after it.

## Timing
- Reset values: Ready=0, MisalignErr=0, ErrCount=0, FSM=INIT, sweep counter=0.
- DMEM_Dout is 0 while reset is asserted.
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge.
- With the sweep, INIT lasts exactly Depth cycles after reset deasserts. Ready rises on the edge that writes word Depth-1, so it is visible the cycle after.
- Reset asserted mid-INIT restarts the sweep from word 0. Reset in READY returns the FSM to INIT.
- A misaligned access on cycle N gives MisalignErr=1 on cycle N+1. Back-to-back misaligned accesses hold MisalignErr high continuously and add one count per cycle.
- ErrCount at 255 stays at 255.

## Configuration
- DMEM_ZERO_INIT_EN defined: INIT performs the Depth-cycle zeroing sweep described above.
- DMEM_ZERO_INIT_EN undefined:
  - INIT lasts one cycle with no array writes, and Ready=1 on the second cycle after reset deasserts.
  - Array contents are uninitialized (X in simulation).
  - The sweep counter is omitted.

## Test plan
- Reset release with DMEM_ZERO_INIT_EN, Depth=1024 → Ready=0 for 1024 cycles then 1. A read of any address afterwards returns 32'h00000000.
- Word store 32'h8123_45F6 at address 0x10, then byte reads with MemExt=1 at 0x10..0x13 → FFFFFF81, 00000023, 00000045, FFFFFFF6. The same reads with MemExt=0 → 00000081, 00000023, 00000045, 000000F6.
- Halfword store 16'hBEEF at 0x22 over an existing word 32'h11223344 at 0x20 → a word read of 0x20 returns 32'h1122BEEF.
- Word store at 0x41 → memory unchanged, DMEM_Dout=0 that cycle, MisalignErr=1 next cycle, ErrCount=1. 300 consecutive misaligned halfword accesses → ErrCount=255.
- Address wrap: store 32'hCAFEF00D at Depth*4+8 → a word read of address 8 returns 32'hCAFEF00D.
- Assert reset at sweep word 500, release → the sweep restarts, Ready stays low for a further 1024 cycles, and ErrCount=0.
